// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  // Requester identifiers; also the bit position in a one-hot grant vector.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Convert a one-hot two-bit grant into the winning port id.
  function automatic logic gnt_to_id(input logic [1:0] gnt);
    return gnt[PORT_D];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,   // bit 0 = fetch, bit 1 = load/store
  input  logic       last_i,  // id of the previous winner
  output logic [1:0] gnt_o    // one-hot grant, all zero when nothing requests
);

  // Combinational one-hot grant selection.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_D) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer merging the instruction-fetch port and the
// load/store port onto one single-port memory (combinational read,
// clocked write). Each transaction runs IDLE -> ACCESS -> RESPOND.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch port (read only)
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // shared memory port
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_e                  state_q;
  logic                    last_q;
  logic                    grant_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    i_ack_q;
  logic                    d_ack_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;

  logic [1:0]              gnt_s;
  logic                    win_s;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic                    we_d;

  rr_arb2 u_rr_arb2 (
    .req_i  ({d_req, i_req}),
    .last_i (last_q),
    .gnt_o  (gnt_s)
  );

  // Select the winner's request fields to be latched at grant.
  always_comb begin
    win_s = gnt_to_id(gnt_s);
    if (win_s == PORT_D) begin
      addr_d  = d_addr;
      wdata_d = d_wdata;
      we_d    = d_we;
    end else begin
      // A fetch never writes; keep the old write data so mem_wdata is quiet.
      addr_d  = i_addr;
      wdata_d = wdata_q;
      we_d    = 1'b0;
    end
  end

  // Transaction FSM with request latches, ack pulses and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= PORT_D;     // fetch wins the first tie after reset
      grant_q   <= PORT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|gnt_s) begin
            state_q <= ACCESS;
            grant_q <= win_s;
            last_q  <= win_s;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          // Reads are captured from the combinational memory output here;
          // a store leaves both rdata registers untouched.
          if (!we_q) begin
            if (grant_q == PORT_D) begin
              d_rdata_q <= mem_rdata;
            end else begin
              i_rdata_q <= mem_rdata;
            end
          end else begin
            d_rdata_q <= d_rdata_q;
          end
          if (grant_q == PORT_D) begin
            d_ack_q <= 1'b1;
          end else begin
            i_ack_q <= 1'b1;
          end
          state_q <= RESPOND;
        end
        RESPOND: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The write strobe is decoded from state; rst masks it so a reset
  // sampled at the ACCESS edge abandons the store without touching memory.
  assign mem_write = (state_q == ACCESS) && we_q && !rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single transactions
// plus hand-written multi-cycle sequences, with a scoreboard of expected acks.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [4:0]  i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [4:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_write;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  // memory model with a bench-side preload path
  logic [31:0] mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] rdata;
  } sb_t;

  typedef struct {
    string       name;
    logic        port;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[10];
  int          n_checks;
  int          n_fail;
  int          cyc;
  int          acks;
  int          wr_cnt;
  int          last_ack_cyc;
  logic [31:0] exp_i_rd;
  logic [31:0] exp_d_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // advance to the next negedge and run the ack/strobe monitor
  task automatic tick();
    sb_t e;
    @(negedge clk);
    cyc++;
    if (i_ack && d_ack) chk("dual_ack", 32'd1, 32'd0);
    if (mem_write) begin
      wr_cnt++;
      if (!busy) chk("write_outside_access", {31'd0, busy}, 32'd1);
    end
    if (i_ack || d_ack) begin
      acks++;
      last_ack_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, d_ack, i_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'd0, d_ack}, {31'd0, e.port});
        if (!e.we) begin
          if (e.port) exp_d_rd = e.rdata;
          else exp_i_rd = e.rdata;
        end
        chk("i_rdata", i_rdata, exp_i_rd);
        chk("d_rdata", d_rdata, exp_d_rd);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    exp_i_rd = 32'd0;
    exp_d_rd = 32'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
    chk({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // one isolated transaction from IDLE; checks latency, busy and write strobe
  task automatic run_txn(input string name, input logic port, input logic we,
                         input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd);
    sb_t e;
    int  a0;
    int  w0;
    int  n;
    e.port  = port;
    e.we    = we;
    e.rdata = exp_rd;
    sb.push_back(e);
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    a0 = acks;
    w0 = wr_cnt;
    n  = 0;
    while (acks == a0 && n < 10) begin
      tick();
      n++;
      if (n == 1) begin
        chk({name, "_busy_access"}, {31'd0, busy}, 32'd1);
        chk({name, "_write_in_access"}, {31'd0, mem_write}, {31'd0, we});
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk({name, "_ack_seen"}, {31'd0, (acks != a0)}, 32'd1);
    if (acks == a0) sb.delete();
    chk({name, "_latency"}, n, 32'd2);
    chk({name, "_write_count"}, wr_cnt - w0, {31'd0, we});
    tick();
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   k;
    int   a0;
    int   n;
    int   prev;
    sb_t  e;

    n_checks = 0; n_fail = 0; cyc = 0; acks = 0; wr_cnt = 0; last_ack_cyc = 0;
    exp_i_rd = 32'd0; exp_d_rd = 32'd0;
    rst = 1'b1; i_req = 1'b0; i_addr = 5'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 5'd0; d_wdata = 32'd0; pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;

    vecs[0] = '{"fetch3",     1'b0, 1'b0, 5'd3,  32'h0,        32'hDEADBEEF};
    vecs[1] = '{"store7",     1'b1, 1'b1, 5'd7,  32'h12345678, 32'h0};
    vecs[2] = '{"load7",      1'b1, 1'b0, 5'd7,  32'h0,        32'h12345678};
    vecs[3] = '{"fetch7",     1'b0, 1'b0, 5'd7,  32'h0,        32'h12345678};
    vecs[4] = '{"store31",    1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 32'h0};
    vecs[5] = '{"load31",     1'b1, 1'b0, 5'd31, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{"load0",      1'b1, 1'b0, 5'd0,  32'h0,        32'h0};
    vecs[7] = '{"fetch31",    1'b0, 1'b0, 5'd31, 32'h0,        32'hA5A5A5A5};
    vecs[8] = '{"store0",     1'b1, 1'b1, 5'd0,  32'h00000005, 32'h0};
    vecs[9] = '{"fetch0",     1'b0, 1'b0, 5'd0,  32'h0,        32'h00000005};

    // preload memory while held in reset
    for (int i = 0; i < 32; i++) begin
      pre_we   = 1'b1;
      pre_addr = i[4:0];
      pre_data = (i == 3) ? 32'hDEADBEEF : 32'h0;
      tick();
    end
    pre_we = 1'b0;
    do_reset();
    tick();
    chk_reset_outputs("reset");

    // table-driven single transactions
    for (int v = 0; v < 10; v++) begin
      run_txn(vecs[v].name, vecs[v].port, vecs[v].we, vecs[v].addr,
              vecs[v].wdata, vecs[v].exp_rd);
    end

    // simultaneous requests after reset: fetch, data, fetch, data
    do_reset();
    tick();
    e.we = 1'b0;
    e.port = 1'b0; e.rdata = 32'hDEADBEEF; sb.push_back(e);
    e.port = 1'b1; e.rdata = 32'h12345678; sb.push_back(e);
    e.port = 1'b0; e.rdata = 32'hDEADBEEF; sb.push_back(e);
    e.port = 1'b1; e.rdata = 32'h12345678; sb.push_back(e);
    i_req = 1'b1; i_addr = 5'd3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 5'd7;
    a0 = acks; n = 0; k = 0; prev = 0;
    while (acks - a0 < 4 && n < 40) begin
      tick();
      n++;
      if (acks - a0 > k) begin
        if (k == 0) chk("tie_first_latency", n, 32'd2);
        else chk("tie_ack_spacing", last_ack_cyc - prev, 32'd3);
        prev = last_ack_cyc;
        k = acks - a0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("tie_ack_count", acks - a0, 32'd4);
    sb.delete();
    tick();
    tick();

    // request dropped and address changed during ACCESS
    e.port = 1'b1; e.we = 1'b0; e.rdata = 32'hDEADBEEF; sb.push_back(e);
    d_req = 1'b1; d_we = 1'b0; d_addr = 5'd3;
    a0 = acks;
    tick();
    chk("drop_busy_access", {31'd0, busy}, 32'd1);
    d_req = 1'b0;
    d_addr = 5'd7;
    n = 1;
    while (acks == a0 && n < 10) begin
      tick();
      n++;
    end
    chk("drop_ack_seen", {31'd0, (acks != a0)}, 32'd1);
    chk("drop_latency", n, 32'd2);
    sb.delete();
    tick();
    chk("drop_idle_busy", {31'd0, busy}, 32'd0);

    // reset during the ACCESS of a store to address 9
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'd9; d_wdata = 32'hCAFEF00D;
    tick();
    chk("rstmid_write_pending", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    d_req = 1'b0;
    a0 = acks;
    tick();
    chk_reset_outputs("rstmid");
    rst = 1'b0;
    exp_i_rd = 32'd0;
    exp_d_rd = 32'd0;
    tick();
    tick();
    tick();
    chk("rstmid_no_ack", acks - a0, 32'd0);
    chk("rstmid_mem9", mem[9], 32'h0);
    run_txn("rstmid_load9", 1'b1, 1'b0, 5'd9, 32'h0, 32'h0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
